// File: rtl/mat_mult_sched.sv
// mat_mult_sched: two-requester round-robin scheduler and sequencer for a
// 2x2 packed-matrix multiply on one shared element MAC (8 MAC cycles/job).
// Optional feature macro: MAT_MULT_SAT_EN (saturating accumulate instead of
// modulo-2^ELEM_W wrap).
module mat_mult_sched #(
    parameter int unsigned ELEM_W     = 8,
    parameter int unsigned PRIO_RESET = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic [4*ELEM_W-1:0] req0_a,
    input  logic [4*ELEM_W-1:0] req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [4*ELEM_W-1:0] req1_a,
    input  logic [4*ELEM_W-1:0] req1_b,
    output logic                req1_ready,
    output logic                res_valid,
    output logic                res_id,
    output logic [4*ELEM_W-1:0] res_data,
    input  logic                res_ready,
    output logic                busy
);
    localparam int unsigned MW = 4 * ELEM_W;
    localparam int unsigned PW = 2 * ELEM_W;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t            state, state_nxt;
    logic              ptr;
    logic              grant0, grant1, accept;
    logic [MW-1:0]     a_r, b_r;
    logic              id_r;
    logic [2:0]        cnt;
    logic [ELEM_W-1:0] acc [4];
    logic [ELEM_W-1:0] a_e [4];
    logic [ELEM_W-1:0] b_e [4];
    logic [1:0]        a_idx, b_idx, c_idx;
    logic [PW-1:0]     prod;
    logic [ELEM_W-1:0] mac_val;

    // Unpack row-major operands; element 0 ([0][0]) sits in the MSBs.
    assign a_e[0] = a_r[MW-1 -: ELEM_W];
    assign a_e[1] = a_r[MW-ELEM_W-1 -: ELEM_W];
    assign a_e[2] = a_r[PW-1 -: ELEM_W];
    assign a_e[3] = a_r[ELEM_W-1:0];
    assign b_e[0] = b_r[MW-1 -: ELEM_W];
    assign b_e[1] = b_r[MW-ELEM_W-1 -: ELEM_W];
    assign b_e[2] = b_r[PW-1 -: ELEM_W];
    assign b_e[3] = b_r[ELEM_W-1:0];

    // cnt = {i, j, k}: A[i][k] * B[k][j] accumulates into C[i][j].
    assign a_idx = {cnt[2], cnt[0]};
    assign b_idx = {cnt[0], cnt[1]};
    assign c_idx = cnt[2:1];
    assign prod  = PW'(a_e[a_idx]) * PW'(b_e[b_idx]);

`ifdef MAT_MULT_SAT_EN
    logic [PW:0] sum_full;

    // Full-width accumulate, clamped to the element maximum.
    always_comb begin
        sum_full = (PW+1)'(acc[c_idx]) + (PW+1)'(prod);
        mac_val  = (|sum_full[PW:ELEM_W]) ? '1 : sum_full[ELEM_W-1:0];
    end
`else
    // Accumulate with modulo-2^ELEM_W wrap.
    always_comb begin
        mac_val = ELEM_W'(PW'(acc[c_idx]) + prod);
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and round-robin grant; readies are masked while in reset.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    grant0 = req0_valid && (!req1_valid || !ptr);
                    grant1 = req1_valid && (!req0_valid ||  ptr);
                end
                if (grant0 || grant1) state_nxt = COMPUTE;
            end
            COMPUTE: if (cnt == 3'd7) state_nxt = DONE;
            DONE:    if (res_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept     = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Job capture, MAC sequencing and round-robin pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr  <= 1'(PRIO_RESET);
            a_r  <= '0;
            b_r  <= '0;
            id_r <= 1'b0;
            cnt  <= '0;
            acc  <= '{default: '0};
        end else begin
            if (state == IDLE && accept) begin
                a_r  <= grant1 ? req1_a : req0_a;
                b_r  <= grant1 ? req1_b : req0_b;
                id_r <= grant1;
                ptr  <= grant0;
                cnt  <= '0;
                acc  <= '{default: '0};
            end else if (state == COMPUTE) begin
                acc[c_idx] <= mac_val;
                cnt        <= cnt + 3'd1;
            end
        end
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_id    = id_r;
    assign res_data  = {acc[0], acc[1], acc[2], acc[3]};

endmodule

// File: tb/tb_mat_mult_sched.sv
// Self-checking bench for mat_mult_sched (ELEM_W=8, PRIO_RESET=0).
// Honours MAT_MULT_SAT_EN when defined for the whole build.
module tb_mat_mult_sched;
    localparam int W = 8;
`ifdef MAT_MULT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_id, res_ready, busy;
    logic [31:0] res_data;

    int n_cmp = 0;
    int n_err = 0;

    mat_mult_sched #(.ELEM_W(W), .PRIO_RESET(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ready(res_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } vec_t;

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], wrapped or clamped per step.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] c;
        int unsigned s, ai, bi;
        c = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++) begin
                    ai = 32'(a[(3 - (2*i + k))*8 +: 8]);
                    bi = 32'(b[(3 - (2*k + j))*8 +: 8]);
                    s  = s + ai * bi;
                    if (SAT) begin
                        if (s > 255) s = 255;
                    end else begin
                        s = s % 256;
                    end
                end
                c[(3 - (2*i + j))*8 +: 8] = 8'(s);
            end
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic who, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (who) begin req1_valid = v; req1_a = a; req1_b = b; end
        else     begin req0_valid = v; req0_a = a; req0_b = b; end
    endtask

    // Called just after a negedge; returns before the accepting posedge.
    task automatic accept(input logic who);
        int cyc = 0;
        #1;
        while (!(req0_ready || req1_ready) && cyc < 40) begin
            @(negedge clk); #1; cyc++;
        end
        check("grant_ready",     32'(who ? req1_ready : req0_ready), 32'd1);
        check("grant_exclusive", 32'(who ? req0_ready : req1_ready), 32'd0);
    endtask

    // Entered at the negedge after the accept edge.
    task automatic collect(input logic eid, input logic [31:0] edata, input int hold);
        int lat = 1;
        while (!res_valid && lat < 40) begin
            @(negedge clk); lat++;
        end
        check("res_valid_seen", 32'(res_valid), 32'd1);
        check("latency", 32'(lat), 32'd9);
        check("res_data", res_data, edata);
        check("res_id", 32'(res_id), 32'(eid));
        check("busy_done", 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", res_data, edata);
            check("hold_id", 32'(res_id), 32'(eid));
            check("hold_no_ready", 32'(req0_ready | req1_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("busy_after", 32'(busy), 32'd0);
        check("valid_after", 32'(res_valid), 32'd0);
    endtask

    task automatic run_job(input logic who, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int hold);
        drive(who, 1'b1, a, b);
        accept(who);
        @(posedge clk);
        @(negedge clk);
        drive(who, 1'b0, a, b);
        collect(who, exp, hold);
    endtask

    vec_t        tbl [8];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    bit          pend [2];
    logic        fav, w;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 32'h01020304, 32'h05060708, 32'h13162B32};
        tbl[1] = '{1'b1, 32'h10101010, 32'h10101010, SAT ? 32'hFFFFFFFF : 32'h00000000};
        tbl[2] = '{1'b0, 32'h01000001, 32'h0A0B0C0D, 32'h0A0B0C0D};
        tbl[3] = '{1'b1, 32'h02000002, 32'h01020304, 32'h02040608};
        tbl[4] = '{1'b0, 32'h80808080, 32'h01010101, SAT ? 32'hFFFFFFFF : 32'h00000000};
        tbl[5] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        tbl[6] = '{1'b0, 32'hFFFFFFFF, 32'h01000001, 32'hFFFFFFFF};
        tbl[7] = '{1'b1, 32'h10000010, 32'h01020304, 32'h10203040};

        reset = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;

        // Reset state, with both requesters asserting valid.
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1, 32'h01020304, 32'h05060708);
        drive(1'b1, 1'b1, 32'h02000002, 32'h01020304);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Contention from reset: req0, then req1, then req0's second job.
        accept(1'b0);
        @(posedge clk); @(negedge clk);
        drive(1'b0, 1'b1, 32'h01000001, 32'h0A0B0C0D);
        collect(1'b0, 32'h13162B32, 0);
        accept(1'b1);
        @(posedge clk); @(negedge clk);
        req1_valid = 1'b0;
        collect(1'b1, 32'h02040608, 0);
        accept(1'b0);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        collect(1'b0, 32'h0A0B0C0D, 0);

        // Directed vector table.
        for (int n = 0; n < 8; n++)
            run_job(tbl[n].id, tbl[n].a, tbl[n].b, tbl[n].c, 0);

        // Backpressure: 5 cycles in DONE with the other requester waiting.
        drive(1'b1, 1'b1, 32'h10000010, 32'h01020304);
        accept(1'b1);
        @(posedge clk); @(negedge clk);
        req1_valid = 1'b0;
        drive(1'b0, 1'b1, 32'h01020304, 32'h05060708);
        collect(1'b1, 32'h10203040, 5);
        accept(1'b0);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        collect(1'b0, 32'h13162B32, 0);

        // Async reset at cnt=4 on a req0 job (pointer now favours req1).
        drive(1'b0, 1'b1, 32'h01020304, 32'h05060708);
        accept(1'b0);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        drive(1'b0, 1'b1, 32'h01000001, 32'h0A0B0C0D);
        drive(1'b1, 1'b1, 32'h02000002, 32'h01020304);
        reset = 1'b1;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_res_data", res_data, 32'd0);
        check("arst_res_id", 32'(res_id), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready0", 32'(req0_ready), 32'd0);
        check("arst_ready1", 32'(req1_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("arst_no_result", 32'(res_valid), 32'd0);
        end
        reset = 1'b0;
        accept(1'b0);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        collect(1'b0, 32'h0A0B0C0D, 0);
        accept(1'b1);
        @(posedge clk); @(negedge clk);
        req1_valid = 1'b0;
        collect(1'b1, 32'h02040608, 0);

        // Randomized traffic against the reference model and fairness rule.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        fav = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int n = 0; n < 24; n++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1; pa[r] = $urandom; pb[r] = $urandom;
                end
            if (!pend[0] && !pend[1]) begin
                w = 1'($urandom_range(0, 1));
                pend[w] = 1'b1; pa[w] = $urandom; pb[w] = $urandom;
            end
            drive(1'b0, pend[0], pa[0], pb[0]);
            drive(1'b1, pend[1], pa[1], pb[1]);
            w = (pend[0] && pend[1]) ? fav : pend[1];
            accept(w);
            @(posedge clk); @(negedge clk);
            pend[w] = 1'b0;
            fav = ~w;
            drive(w, 1'b0, pa[w], pb[w]);
            collect(w, ref_mul(pa[w], pb[w]), int'($urandom_range(0, 3)));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mat_mult_sched.md
# mat_mult_sched

Two-requester scheduler and sequencer for the 2x2 packed-matrix multiply datapath used by the NN layers. It accepts jobs (two packed 2x2 matrices) from two independent requesters and arbitrates between them round-robin. It steps a single shared element MAC through the eight i/j/k products, then returns the packed result, tagged with the requester ID, over a valid/ready handshake. One job is in flight at a time.

## Interface
Parameters:
- ELEM_W, default 8: element width. Packed matrices are 4*ELEM_W bits, row-major {[0][0],[0][1],[1][0],[1][1]}, with [0][0] in the MSBs.
- PRIO_RESET, default 0: the requester that wins the first simultaneous request after reset.

Ports:
- clk  in  1  the only clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req0_valid  in  1  requester 0 has a job.
- req0_a  in  4*ELEM_W  packed matrix A for requester 0.
- req0_b  in  4*ELEM_W  packed matrix B for requester 0.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready: same as the requester 0 ports, for requester 1.
- res_valid  out  1  result available.
- res_id  out  1  requester that owns the result.
- res_data  out  4*ELEM_W  packed result C = A*B.
- res_ready  in  1  consumer takes the result.
- busy  out  1  high in COMPUTE and DONE.

## Operation
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - reqN_ready is driven combinationally and is high only for the granted requester.
  - Grant rule: the requester whose valid is alone wins. If both are valid, the requester selected by the round-robin pointer wins.
  - On valid&ready: capture A, B and the ID; clear all four accumulators; set the MAC counter to 0; set the pointer to the other requester; go to COMPUTE.
- COMPUTE:
  - 3-bit counter cnt runs 0..7, with i=cnt[2], j=cnt[1], k=cnt[0].
  - Each cycle: acc[i][j] <= acc[i][j] + A[i][k]*B[k][j].
  - Width rule: the product is formed at 2*ELEM_W bits; the sum is truncated to ELEM_W bits (modulo 2^ELEM_W).
  - On cnt==7, go to DONE.
- DONE:
  - res_valid=1; res_data and res_id are held stable.
  - On res_valid&res_ready, go to IDLE.
  - No job is accepted in DONE.
- Requesters must hold valid, a and b stable until ready. A request withdrawn before ready is not an error; it is simply not accepted.
- Reset mid-operation: the job is aborted silently and no result is produced. The pointer returns to PRIO_RESET.

## Timing
- Reset values:
  - State IDLE, pointer = PRIO_RESET.
  - res_valid=0, res_id=0, res_data=0, busy=0.
  - req0_ready and req1_ready are forced 0 while reset is high.
- Latency: with the accept edge as E0, MACs occur on E1..E8 and res_valid is high in the cycle after E8. That is 9 cycles from accept to result.
- Minimum job period is 10 cycles: the result handshake at E9 returns the FSM to IDLE, and the next accept is at E10.
- res_data is the final accumulator value, registered; it does not change while res_valid is high.
- Simultaneous requests: exactly one ready is asserted per accept. The loser keeps its valid high and is accepted on the next IDLE visit, because the pointer then favours it.
- A request arriving while busy is not accepted until the FSM is back in IDLE.

## Configuration
- MAT_MULT_SAT_EN:
  - Defined: each accumulate is computed at full width and clamped to 2^ELEM_W-1. A product larger than that value also saturates.
  - Undefined: modulo-2^ELEM_W wrap, as described in Operation.

## Test plan
- Single job: req0 with A=0x01020304, B=0x05060708 -> res_valid 9 cycles after accept, res_data=0x13162B32, res_id=0, busy falls after the handshake.
- Overflow: A=B=0x10101010 -> res_data=0x00000000 without MAT_MULT_SAT_EN, and 0xFFFFFFFF with it.
- Contention: both requesters valid from reset with PRIO_RESET=0 -> req0 is served first and req1 second. If req0 asserts valid again, requester 1's result precedes requester 0's next result.
- Backpressure: res_ready held low for 5 cycles in DONE -> res_valid, res_data and res_id are stable, and both reqN_ready stay 0.
- Async reset asserted at cnt=4 -> outputs reach reset values immediately and no res_valid pulse occurs. A following job (A=0x01000001 identity, B=0x0A0B0C0D) -> res_data=0x0A0B0C0D.
